boot_loader: RTL and testbench

Boot sequencer for the RV32I single-cycle processor. It holds the core in reset, receives a program image as a byte stream from a serial front end, and writes the image word by word into instruction memory starting at word address 0. After the image is complete and its checksum passes, it releases the core. It sits between the byte receiver, the instruction-memory write port and the processor's `reset` input.

---
 rtl/boot_loader.sv | 156 +++++++++++++++
 tb/tb_boot_loader.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/boot_loader.sv
// Boot sequencer: holds the RV32I core in reset, streams a length-prefixed image into IM, then releases it.
// Optional trailing XOR checksum byte is compiled in with `define BOOT_CSUM_EN.
module boot_loader #(
   parameter int ADDR_WIDTH = 10
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  start,
   input  logic [7:0]            rx_data,
   input  logic                  rx_valid,
   output logic                  rx_ready,
   output logic                  im_we,
   output logic [ADDR_WIDTH-1:0] im_addr,
   output logic [31:0]           im_wdata,
   output logic                  cpu_reset,
   output logic                  busy,
   output logic                  done,
   output logic                  error
);

`ifdef BOOT_CSUM_EN
   typedef enum logic [2:0] {IDLE, LEN_LO, LEN_HI, DATA, CSUM, RUN, ERR} state_t;
   localparam state_t TAIL = CSUM;
`else
   typedef enum logic [2:0] {IDLE, LEN_LO, LEN_HI, DATA, RUN, ERR} state_t;
   localparam state_t TAIL = RUN;
`endif

   state_t state_q, state_d;

   logic [7:0]  len_lo;
   logic [15:0] len_q;
   logic [15:0] wcnt;
   logic [1:0]  byte_idx;
   logic [23:0] word_buf;
`ifdef BOOT_CSUM_EN
   logic [7:0]  csum_q;
`endif

   logic [15:0] len_n;
   logic        len_big;
   logic        last_word;
   logic        accept;
   logic        reload;

   assign len_n     = {rx_data, len_lo};
   // Capacity is 2^ADDR_WIDTH words; an exact-fit image is legal.
   assign len_big   = {1'b0, len_n} > (17'd1 << ADDR_WIDTH);
   assign last_word = (wcnt == len_q - 16'd1);
   assign accept    = rx_valid && rx_ready;
   assign reload    = start && (state_q == IDLE || state_q == RUN || state_q == ERR);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) state_q <= IDLE;
      else        state_q <= state_d;
   end

   always_comb begin
      state_d   = state_q;
      rx_ready  = 1'b0;
      busy      = 1'b0;
      done      = 1'b0;
      error     = 1'b0;
      cpu_reset = 1'b1;
      case (state_q)
         IDLE: if (start) state_d = LEN_LO;
         LEN_LO: begin
            rx_ready = 1'b1;
            busy     = 1'b1;
            if (rx_valid) state_d = LEN_HI;
         end
         LEN_HI: begin
            rx_ready = 1'b1;
            busy     = 1'b1;
            if (rx_valid) begin
               if (len_big)            state_d = ERR;
               else if (len_n == 16'd0) state_d = TAIL;
               else                    state_d = DATA;
            end
         end
         DATA: begin
            rx_ready = 1'b1;
            busy     = 1'b1;
            if (rx_valid && byte_idx == 2'd3 && last_word) state_d = TAIL;
         end
`ifdef BOOT_CSUM_EN
         CSUM: begin
            rx_ready = 1'b1;
            busy     = 1'b1;
            if (rx_valid) state_d = (rx_data == csum_q) ? RUN : ERR;
         end
`endif
         RUN: begin
            done      = 1'b1;
            cpu_reset = 1'b0;
            if (start) state_d = LEN_LO;
         end
         ERR: begin
            error = 1'b1;
            if (start) state_d = LEN_LO;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         len_lo   <= '0;
         len_q    <= '0;
         wcnt     <= '0;
         byte_idx <= '0;
         word_buf <= '0;
         im_we    <= 1'b0;
         im_addr  <= '0;
         im_wdata <= '0;
`ifdef BOOT_CSUM_EN
         csum_q   <= '0;
`endif
      end else begin
         im_we <= 1'b0;
         if (reload) begin
            wcnt     <= '0;
            byte_idx <= '0;
`ifdef BOOT_CSUM_EN
            csum_q   <= '0;
`endif
         end
         if (accept) begin
            case (state_q)
               LEN_LO: len_lo <= rx_data;
               LEN_HI: len_q  <= len_n;
               DATA: begin
                  byte_idx <= byte_idx + 2'd1;
`ifdef BOOT_CSUM_EN
                  csum_q   <= csum_q ^ rx_data;
`endif
                  case (byte_idx)
                     2'd0: word_buf[7:0]   <= rx_data;
                     2'd1: word_buf[15:8]  <= rx_data;
                     2'd2: word_buf[23:16] <= rx_data;
                     default: begin
                        // Last lane goes straight to the write port; no need to buffer it.
                        im_we    <= 1'b1;
                        im_addr  <= wcnt[ADDR_WIDTH-1:0];
                        im_wdata <= {rx_data, word_buf};
                        wcnt     <= wcnt + 16'd1;
                     end
                  endcase
               end
               default: ;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_boot_loader.sv
// Directed bench for boot_loader: scoreboard of expected IM writes checked by a negedge monitor.
module tb_boot_loader;
   localparam int AW = 10;

   logic          clk = 1'b0;
   logic          reset;
   logic          start;
   logic [7:0]    rx_data;
   logic          rx_valid;
   logic          rx_ready;
   logic          im_we;
   logic [AW-1:0] im_addr;
   logic [31:0]   im_wdata;
   logic          cpu_reset;
   logic          busy;
   logic          done;
   logic          error;

   typedef struct packed {
      logic [AW-1:0] addr;
      logic [31:0]   data;
   } wr_t;

   wr_t         exp_q[$];
   logic [31:0] img[$];
   int          tests = 0;
   int          fails = 0;
   logic        prev_we = 1'b0;

   boot_loader #(.ADDR_WIDTH(AW)) dut (
      .clk(clk), .reset(reset), .start(start), .rx_data(rx_data), .rx_valid(rx_valid),
      .rx_ready(rx_ready), .im_we(im_we), .im_addr(im_addr), .im_wdata(im_wdata),
      .cpu_reset(cpu_reset), .busy(busy), .done(done), .error(error)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Outputs packed as {rx_ready, busy, done, error, cpu_reset}.
   task automatic chk_outs(input string tag, input logic [4:0] exp);
      chk(tag, {59'd0, rx_ready, busy, done, error, cpu_reset}, {59'd0, exp});
   endtask

   always @(negedge clk) begin
      if (im_we) begin
         chk("we_one_cycle", {63'd0, prev_we}, 64'd0);
         if (exp_q.size() == 0) begin
            tests++;
            fails++;
            $error("FAIL unexpected_write: got addr %0h data %0h expected none", im_addr, im_wdata);
         end else begin
            wr_t e;
            e = exp_q.pop_front();
            chk("wr_addr", {54'd0, im_addr}, {54'd0, e.addr});
            chk("wr_data", {32'd0, im_wdata}, {32'd0, e.data});
         end
      end
      prev_we = im_we;
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic pulse_start();
      start = 1'b1;
      tick();
      start = 1'b0;
   endtask

   task automatic send_byte(input logic [7:0] b, input int gap);
      int t;
      t = 0;
      rx_valid = 1'b0;
      repeat (gap) tick();
      rx_valid = 1'b1;
      rx_data  = b;
      while (!rx_ready && t < 50) begin
         tick();
         t++;
      end
      if (t == 50) begin
         tests++;
         fails++;
         $error("FAIL rx_ready_timeout: got rx_ready 0 expected 1");
      end
      tick();
      rx_valid = 1'b0;
   endtask

   // Sends length, img payload and (if built in) checksum; start_at pulses start before that payload byte.
   task automatic send_image(input logic [15:0] n, input bit bad_csum, input int gap_max,
                             input int start_at);
      logic [7:0] b, cs;
      int k;
      cs = 8'h00;
      k  = 0;
      send_byte(n[7:0], 0);
      send_byte(n[15:8], 0);
      for (int i = 0; i < int'(n); i++) begin
         for (int j = 0; j < 4; j++) begin
            b = img[i][8*j +: 8];
            if (k == start_at) begin
               pulse_start();
               chk("start_ignored_busy", {63'd0, busy}, 64'd1);
            end
            if (j == 3) exp_q.push_back('{addr: AW'(i), data: img[i]});
            send_byte(b, int'($urandom_range(0, gap_max)));
            cs ^= b;
            k++;
         end
      end
`ifdef BOOT_CSUM_EN
      send_byte(bad_csum ? (cs ^ 8'h01) : cs, 0);
`else
      if (bad_csum) cs = 8'h00;
`endif
   endtask

   task automatic drain(input string tag);
      repeat (2) tick();
      chk(tag, 64'(exp_q.size()), 64'd0);
   endtask

   initial begin
      reset = 1'b0; start = 1'b0; rx_valid = 1'b0; rx_data = 8'h00;
      repeat (3) tick();
      chk_outs("reset_outs", 5'b00001);
      chk("reset_addr", {54'd0, im_addr}, 64'd0);
      chk("reset_wdata", {32'd0, im_wdata}, 64'd0);
      reset = 1'b1;
      tick();
      chk_outs("idle_outs", 5'b00001);

      // Nominal load
      img = '{32'h00500013, 32'h00100093};
      pulse_start();
      chk_outs("start_latency", 5'b11001);
      send_image(16'd2, 1'b0, 0, -1);
      chk_outs("nominal_run", 5'b00100);
      drain("nominal_writes");
      chk("hold_addr", {54'd0, im_addr}, 64'd1);
      chk("hold_wdata", {32'd0, im_wdata}, 64'h00100093);

      // Reload from RUN reasserts core reset the next cycle
      pulse_start();
      chk_outs("reload_from_run", 5'b11001);
`ifdef BOOT_CSUM_EN
      send_image(16'd2, 1'b1, 0, -1);
      chk_outs("csum_mismatch", 5'b00011);
      drain("mismatch_writes");
      pulse_start();
`else
      send_image(16'd2, 1'b0, 0, -1);
      drain("reload_writes");
      chk_outs("reload_run", 5'b00100);
      pulse_start();
`endif

      // Zero length
      send_byte(8'h00, 0);
      send_byte(8'h00, 0);
`ifdef BOOT_CSUM_EN
      chk_outs("zero_len_csum", 5'b11001);
      send_byte(8'h00, 0);
`endif
      chk_outs("zero_len_run", 5'b00100);
      drain("zero_len_nowrite");

      // Overflow: N = 2^AW + 1 is rejected, payload not consumed
      pulse_start();
      send_byte(8'h01, 0);
      send_byte(8'h04, 0);
      chk_outs("overflow_err", 5'b00011);
      rx_valid = 1'b1;
      rx_data  = 8'hAA;
      repeat (4) tick();
      chk_outs("overflow_no_consume", 5'b00011);
      rx_valid = 1'b0;
      drain("overflow_nowrite");

      // Exact-capacity image is accepted and fills through the last address
      img.delete();
      for (int i = 0; i < 1024; i++) img.push_back($urandom);
      pulse_start();
      send_image(16'h0400, 1'b0, 0, -1);
      chk_outs("full_image_run", 5'b00100);
      drain("full_image_writes");
      chk("full_last_addr", {54'd0, im_addr}, 64'd1023);

      // Backpressure with a start pulse mid-DATA
      img = '{32'h00500013, 32'h00100093};
      pulse_start();
      send_image(16'd2, 1'b0, 3, 5);
      chk_outs("backpressure_run", 5'b00100);
      drain("backpressure_writes");

      // Reset mid-load after 5 payload bytes
      pulse_start();
      send_byte(8'h02, 0);
      send_byte(8'h00, 0);
      for (int j = 0; j < 5; j++) begin
         if (j == 3) exp_q.push_back('{addr: AW'(0), data: img[0]});
         send_byte(img[j/4][8*(j%4) +: 8], 0);
      end
      chk_outs("mid_load_busy", 5'b11001);
      reset = 1'b0;
      #1;
      chk_outs("abort_outs", 5'b00001);
      chk("abort_addr", {54'd0, im_addr}, 64'd0);
      chk("abort_wdata", {32'd0, im_wdata}, 64'd0);
      repeat (2) tick();
      reset = 1'b1;
      tick();
      chk("abort_writes", 64'(exp_q.size()), 64'd0);
      pulse_start();
      send_image(16'd2, 1'b0, 0, -1);
      chk_outs("after_abort_run", 5'b00100);
      drain("after_abort_writes");

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
